// File: rtl/funrv32_reg_access.sv
// Operand-read sequencer for the single-read-port funrv32 register file: two serialized reads,
// x0 as zero, write forwarding, writeback pass-through. Optional macro: FUNRV32_RA_SNOOP_EN.
module funrv32_reg_access #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_op1,
    output logic [XLEN-1:0] rsp_op2,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_ad,
    output logic [XLEN-1:0] rf_rd,
    output logic [AW-1:0]   rf_a1,
    input  logic [XLEN-1:0] rf_r1
);

`ifdef FUNRV32_RA_SNOOP_EN
    localparam bit SnoopEn = 1'b1;
`else
    localparam bit SnoopEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_CAP,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs1_d;
    logic [AW-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic            fwd_q, fwd_d;
    logic [XLEN-1:0] fwd_data_q, fwd_data_d;
    logic            wb_live;
    logic            hit1;
    logic            hit2;

    assign wb_live = wb_valid & (wb_rd != '0);
    assign hit1    = wb_live & (wb_rd == rs1_q);
    assign hit2    = wb_live & (wb_rd == rs2_q);

    assign rf_we = wb_live & ~reset;
    assign rf_ad = wb_rd;
    assign rf_rd = wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // A single forward slot is shared: RD1 fills it for rs1 (consumed in RD2),
    // RD2 refills it for rs2 (consumed in CAP).
    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                fwd_d      = hit1;
                fwd_data_d = wb_data;
                state_d    = S_RD2;
            end
            S_RD2: begin
                op1_d      = (rs1_q == '0) ? '0 : (fwd_q ? fwd_data_q : rf_r1);
                fwd_d      = hit2;
                fwd_data_d = wb_data;
                state_d    = S_CAP;
            end
            S_CAP: begin
                op2_d = (rs2_q == '0) ? '0 : (fwd_q ? fwd_data_q : rf_r1);
                fwd_d = 1'b0;
                if (SnoopEn && hit1) op1_d = wb_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (SnoopEn && hit1) op1_d = wb_data;
                if (SnoopEn && hit2) op2_d = wb_data;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        case (state_q)
            S_RD1:   rf_a1 = rs1_q;
            S_RD2:   rf_a1 = rs2_q;
            default: rf_a1 = '0;
        endcase
    end

    assign rsp_op1 = op1_q;
    assign rsp_op2 = op2_q;

endmodule

// File: tb/tb_funrv32_reg_access.sv
// Randomized self-checking bench for funrv32_reg_access with a behavioural register file and
// architectural-state reference model. Honours FUNRV32_RA_SNOOP_EN when defined.
module tb_funrv32_reg_access;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_op1;
    logic [31:0] rsp_op2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_ad;
    logic [31:0] rf_rd;
    logic [4:0]  rf_a1;
    logic [31:0] rf_r1;

    int          checks;
    int          errors;
    logic        tb_clear;
    logic        rand_en;
    logic [31:0] arch   [32];
    logic [31:0] rf_mem [32];

    funrv32_reg_access #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_ad(rf_ad), .rf_rd(rf_rd), .rf_a1(rf_a1), .rf_r1(rf_r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file without x0 handling (cell 0 holds junk) plus the architectural reference state.
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 32; i++) begin
                rf_mem[i] <= (i == 0) ? 32'hBAD0_BAD0 : 32'h0;
                arch[i]   <= 32'h0;
            end
            rf_r1 <= 32'h0;
        end else begin
            if (rf_we) rf_mem[rf_ad] <= rf_rd;
            rf_r1 <= rf_mem[rf_a1];
            if (!reset && wb_valid && wb_rd != 5'd0) arch[wb_rd] <= wb_data;
        end
    end

    function automatic logic [4:0] pick_rs();
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic drive_wb(input int c, input int fcyc, input logic [4:0] frd, input logic [31:0] fdata,
                            input logic [4:0] r1, input logic [4:0] r2);
        if (c == fcyc) begin
            wb_valid = 1'b1; wb_rd = frd; wb_data = fdata;
        end else if (rand_en) begin
            wb_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       wb_rd = r1;
                1:       wb_rd = r2;
                2:       wb_rd = 5'd0;
                default: wb_rd = 5'($urandom_range(0, 31));
            endcase
            wb_data = $urandom;
        end else begin
            wb_valid = 1'b0;
        end
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // One full transaction; each cycle is observed at the falling edge. Operand expectations are
    // the architectural values right after each operand's read-issue cycle.
    task automatic run_req(input logic [4:0] r1, input logic [4:0] r2, input int unsigned hold,
                           input int fcyc, input logic [4:0] frd, input logic [31:0] fdata,
                           output logic [31:0] obs1, output logic [31:0] obs2);
        logic [31:0] e1, e2, w_d;
        logic        w_v;
        logic [4:0]  w_rd;
        e1 = '0; e2 = '0; obs1 = '0; obs2 = '0; w_v = 1'b0; w_rd = '0; w_d = '0;
        req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2;
        drive_wb(0, fcyc, frd, fdata, r1, r2);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready got %b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) e1 = (r1 == 5'd0) ? 32'h0 : arch[r1];
            if (c == 3) e2 = (r2 == 5'd0) ? 32'h0 : arch[r2];
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL busy_cycle%0d got valid=%b ready=%b want 0/0", c, rsp_valid, req_ready);
            end
            if (c <= 2) begin
                checks++;
                if (rf_a1 !== ((c == 1) ? r1 : r2)) begin
                    errors++; $display("FAIL rf_a1_cycle%0d got %0d want %0d", c, rf_a1, (c == 1) ? r1 : r2);
                end
            end
            drive_wb(c, fcyc, frd, fdata, r1, r2);
            w_v = wb_valid; w_rd = wb_rd; w_d = wb_data;
            @(negedge clk);
        end
`ifdef FUNRV32_RA_SNOOP_EN
        if (w_v && w_rd == r1 && r1 != 5'd0) e1 = w_d;
`endif
        for (int unsigned k = 0; k <= hold; k++) begin
            rsp_ready = (k == hold);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++; $display("FAIL resp_cycle%0d got valid=%b ready=%b want 1/0", k, rsp_valid, req_ready);
            end
            checks++;
            if (rsp_op1 !== e1 || rsp_op2 !== e2) begin
                errors++;
                $display("FAIL operands r%0d/r%0d got %h/%h want %h/%h", r1, r2, rsp_op1, rsp_op2, e1, e2);
            end
            obs1 = rsp_op1; obs2 = rsp_op2;
            drive_wb(4 + int'(k), fcyc, frd, fdata, r1, r2);
            w_v = wb_valid; w_rd = wb_rd; w_d = wb_data;
            @(negedge clk);
`ifdef FUNRV32_RA_SNOOP_EN
            if (k < hold && w_v && w_rd != 5'd0) begin
                if (w_rd == r1) e1 = w_d;
                if (w_rd == r2) e2 = w_d;
            end
`endif
        end
        rsp_ready = 1'b0; wb_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL resp_drop got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_op1 !== 32'h0 || rsp_op2 !== 32'h0 || rf_a1 !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%b op1=%h op2=%h a1=%0d want 0/0/0/0", rsp_valid, rsp_op1, rsp_op2, rf_a1);
        end
        reset = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] o1, o2;
        write_reg(5'd5, 32'hDEAD_BEEF);
        run_req(5'd5, 5'd0, 0, -1, 5'd0, 32'h0, o1, o2);
        checks++;
        if (o1 !== 32'hDEAD_BEEF || o2 !== 32'h0) begin
            errors++; $display("FAIL basic got %h/%h want deadbeef/00000000", o1, o2);
        end
    endtask

    task automatic test_x0();
        logic [31:0] o1, o2;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", rf_we); end
        @(negedge clk);
        wb_valid = 1'b0;
        run_req(5'd0, 5'd0, 0, -1, 5'd0, 32'h0, o1, o2);
        checks++;
        if (o1 !== 32'h0 || o2 !== 32'h0) begin
            errors++; $display("FAIL x0_read got %h/%h want 0/0", o1, o2);
        end
    endtask

    task automatic test_forward();
        logic [31:0] o1, o2;
        write_reg(5'd7, 32'h11);
        run_req(5'd7, 5'd7, 0, 1, 5'd7, 32'h22, o1, o2);
        checks++;
        if (o1 !== 32'h22 || o2 !== 32'h22) begin
            errors++; $display("FAIL forward got %h/%h want 22/22", o1, o2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] o1, o2;
        rand_en = 1'b1;
        run_req(pick_rs(), pick_rs(), 3, -1, 5'd0, 32'h0, o1, o2);
        run_req(pick_rs(), pick_rs(), 0, -1, 5'd0, 32'h0, o1, o2);
        rand_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_rs1 = 5'd4; req_rs2 = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = $urandom;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we got %b want 0", rf_we); end
        @(negedge clk);
        reset = 1'b0; wb_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_op1 !== 32'h0 || rsp_op2 !== 32'h0) begin
            errors++; $display("FAIL mid_reset_clear got valid=%b op1=%h op2=%h want 0", rsp_valid, rsp_op1, rsp_op2);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_norsp cycle%0d got 1 want 0", i); end
            @(negedge clk);
        end
    endtask

    task automatic test_snoop();
        logic [31:0] o1, o2, want;
`ifdef FUNRV32_RA_SNOOP_EN
        want = 32'h2;
`else
        want = 32'h1;
`endif
        write_reg(5'd9, 32'h1);
        run_req(5'd3, 5'd9, 1, 4, 5'd9, 32'h2, o1, o2);
        checks++;
        if (o2 !== want) begin errors++; $display("FAIL snoop got %h want %h", o2, want); end
    endtask

    task automatic test_random();
        logic [31:0] o1, o2;
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_req(pick_rs(), pick_rs(), $urandom_range(0, 3), -1, 5'd0, 32'h0, o1, o2);
            if ($urandom_range(0, 1) == 1) begin
                drive_wb(0, -1, 5'd0, 32'h0, pick_rs(), pick_rs());
                @(negedge clk);
                wb_valid = 1'b0;
            end
        end
        rand_en = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        tb_clear = 1'b1; rand_en = 1'b0;
        reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        @(negedge clk);
        tb_clear = 1'b0;
        test_reset();
        test_basic();
        test_x0();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_snoop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
